store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart to the datapath's lh/lb load extension: executes sw/sh/sb against a word-only 32-bit data memory.
- Full-word stores go out as a single write.
- Half and byte stores use a read-modify-write sequence: read the word, merge the new lane, write the word back.
- Sits between the core's memory-stage outputs (aluout as address, writedata, half/b controls) and the data memory handshake. The core stalls while req_ready is low.

Parameters:
- AW, 32, address width
- DW, 32, data width; fixed at 32, since lane logic assumes 4 byte lanes

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  store request from core
- req_ready  out  1  unit idle and accepting a request
- req_addr  in  AW  byte address (core aluout)
- req_data  in  DW  store data (core writedata)
- req_half  in  1  halfword store
- req_byte  in  1  byte store; has priority over req_half
- done  out  1  one-cycle pulse: store committed to memory
- misalign  out  1  one-cycle pulse: halfword at odd address, store dropped
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word-aligned address, bits [1:0] = 00
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid with mem_ack when mem_we = 0
- mem_ack  in  1  memory completes the current request this cycle

Behaviour:
- Reset (reset = 0, asynchronous) forces state IDLE and clears all registers.
  - Output values during reset: req_ready = 1, done = 0, misalign = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Reset mid-transaction abandons the transaction; mem_req drops immediately and no done is produced.
- Size decode:
  - req_byte = 1 selects BYTE, whatever req_half is.
  - Otherwise req_half = 1 selects HALF.
  - Otherwise WORD.
- Acceptance:
  - Accept when req_valid && req_ready. Only IDLE is ready.
  - Latch addr, data and size at acceptance; later changes on the request inputs are ignored.
- Lane order is little-endian.
  - BYTE lane k = addr[1:0]; the merge replaces rdata[8k+7:8k] with data[7:0].
  - HALF lane = addr[1]; the merge replaces rdata[16·addr[1]+15 : 16·addr[1]] with data[15:0].
  - WORD writes data unchanged; addr[1:0] is ignored.
- FSM transitions:
  - IDLE: WORD goes to WR. BYTE goes to RD. HALF goes to FAULT if addr[0] = 1, else RD.
  - RD: mem_req = 1, mem_we = 0. On mem_ack, capture the merged word into the wdata register and go to WR.
  - WR: mem_req = 1, mem_we = 1, mem_wdata = the registered word. On mem_ack go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
  - FAULT: misalign = 1 for one cycle with no memory access, then IDLE.
- mem_addr = {latched addr[AW-1:2], 2'b00} in RD and WR; it is held stable while mem_req is high.
- mem_req, mem_we and mem_wdata are stable until mem_ack. A zero-wait ack (mem_ack in the first cycle of mem_req) is legal.
- mem_ack outside RD/WR is ignored.
- Latency from the accept edge, with zero-wait memory:
  - WORD: WR in cycle 1, done in cycle 2.
  - BYTE/HALF: RD in cycle 1, WR in cycle 2, done in cycle 3.
- req_ready is low from the cycle after acceptance through DONE/FAULT, so back-to-back requests are spaced by at least 3 cycles (WORD) or 4 cycles (BYTE/HALF).

Decomposition:
- lsu_pkg:
  - state enum: IDLE, RD, WR, DONE, FAULT
  - size enum: SZ_WORD, SZ_HALF, SZ_BYTE
  - constants: lane count 4, byte width 8
- Sub-module store_merge (combinational): inputs old word, new data, addr[1:0] and size; output is the merged word. The WORD case passes the new data through.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, zero-wait ack -> a single mem write at 0x100 with wdata 0xDEADBEEF; no read issued; done in cycle 2.
- sb addr 0x103, data 0x000000AA, mem word 0x11223344 -> read at 0x100, write 0xAA223344, done once; repeat for lanes 0, 1 and 2, giving 0x112233AA, 0x1122AA44 and 0x11AA3344.
- sh addr 0x202, data 0x0000BEEF, mem word 0x11223344 -> write 0xBEEF3344; sh addr 0x200 -> write 0x1122BEEF.
- sh addr 0x201 -> misalign pulses for 1 cycle, mem_req never asserts, no done; req_half = req_byte = 1 at addr 0x201 -> treated as a byte store, no misalign.
- ack delayed 3 cycles in both RD and WR, with req_addr/req_data toggling meanwhile -> mem_addr and mem_wdata stay stable, the latched values are used, and req_ready stays 0 until after done.
- reset asserted while in WR -> mem_req drops immediately, no done; after release req_ready = 1 and the next sw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the store path: FSM states, access size
// and the byte-lane geometry of a 32-bit word.
package lsu_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 2 * BYTE_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  // Byte select wins over half select when both are raised.
  function automatic size_e decode_size(input logic is_half, input logic is_byte);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: drops the low byte/half of the store data into
// the addressed little-endian lane of the word read back from memory.
module store_merge
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] old_word,
  input  logic [DW-1:0] new_data,
  input  logic [1:0]    lane,
  input  logic [1:0]    size,
  output logic [DW-1:0] merged
);

  always_comb begin
    merged = new_data;
    case (size)
      SZ_BYTE: begin
        merged = old_word;
        for (int k = 0; k < LANES; k++) begin
          if (lane == k[1:0]) merged[k*BYTE_W +: BYTE_W] = new_data[BYTE_W-1:0];
        end
      end
      SZ_HALF: begin
        merged = old_word;
        if (lane[1]) merged[HALF_W +: HALF_W] = new_data[HALF_W-1:0];
        else         merged[0 +: HALF_W]      = new_data[HALF_W-1:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: sw goes out as one write; sh/sb do read-merge-write against a
// word-only data memory. Misaligned halfwords are dropped with a fault pulse.
module store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic          req_half,
  input  logic          req_byte,
  output logic          done,
  output logic          misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  state_e        state_q;
  size_e         size_q;
  size_e         req_size;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] merged;

  assign req_size = decode_size(req_half, req_byte);

  // wdata_q holds the raw store data until the read returns, then the merged word.
  store_merge #(.DW(DW)) u_merge (
    .old_word (mem_rdata),
    .new_data (wdata_q),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= SZ_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_data;
            size_q  <= req_size;
            if (req_size == SZ_WORD)                   state_q <= WR;
            else if (req_size == SZ_HALF && req_addr[0]) state_q <= FAULT;
            else                                       state_q <= RD;
          end
        end
        RD: begin
          if (mem_ack) begin
            wdata_q <= merged;
            state_q <= WR;
          end
        end
        WR:      if (mem_ack) state_q <= DONE;
        DONE:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign misalign  = (state_q == FAULT);
  assign mem_req   = (state_q == RD) || (state_q == WR);
  assign mem_we    = (state_q == WR);
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// Randomised bench for store_unit: word-memory responder with variable ack
// latency and a reference model that predicts every memory access.
module tb_store_unit;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_half;
  logic        req_byte;
  logic        done;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks;
  int failures;
  int mem_lat;
  op_t ops[$];
  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  store_unit #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_half  (req_half),
    .req_byte  (req_byte),
    .done      (done),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] lo, input logic h, input logic b);
    int sh;
    if (b) begin
      sh = int'(lo) * 8;
      return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end
    if (h) begin
      sh = lo[1] ? 16 : 0;
      return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    tb_mem[a]  = v;
    ref_mem[a] = v;
  endtask

  // Memory responder: ack after mem_lat idle cycles (random 0..3 when negative).
  initial begin
    int  wcnt;
    bit  in_req;
    wcnt = 0;
    in_req = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ack = 1'b0;
        in_req = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          in_req = 0;
        end
        if (mem_req && !in_req) begin
          in_req = 1;
          wcnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
        mem_rdata = $urandom;
        if (in_req) begin
          if (wcnt == 0) begin
            mem_ack = 1'b1;
            ops.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
            else        mem_rdata = tb_rd(mem_addr);
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic h, input logic b,
                          input int lat, input bit toggle, output logic [31:0] last_wr);
    op_t         exp_q[$];
    logic [31:0] wa;
    logic [31:0] nw;
    bit          ex_mis;
    bit          rmw;
    int          done_k;
    int          n_done;
    int          n_mis;
    int          n_busy;
    int          n_unst;
    bit          mreq_seen;
    logic        pv_req;
    logic        pv_ack;
    logic        pv_we;
    logic [31:0] pv_addr;
    logic [31:0] pv_wd;

    wa = {a[31:2], 2'b00};
    ex_mis = !b && h && a[0];
    rmw = b || h;
    last_wr = 32'h0;
    if (!ex_mis) begin
      if (rmw) begin
        exp_q.push_back('{we: 1'b0, addr: wa, data: 32'h0});
        nw = ref_merge(ref_rd(wa), d, a[1:0], h, b);
      end else begin
        nw = d;
      end
      exp_q.push_back('{we: 1'b1, addr: wa, data: nw});
      ref_mem[wa] = nw;
    end

    mem_lat = lat;
    ops.delete();
    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_half  = h;
    req_byte  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    done_k = 0; n_done = 0; n_mis = 0; n_busy = 0; n_unst = 0; mreq_seen = 0;
    pv_req = 1'b0; pv_ack = 1'b0; pv_we = 1'b0; pv_addr = 32'h0; pv_wd = 32'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (done)      n_done++;
      if (misalign)  n_mis++;
      if (mem_req)   mreq_seen = 1;
      if (req_ready) n_busy++;
      if (pv_req && !pv_ack &&
          (mem_req !== 1'b1 || mem_we !== pv_we || mem_addr !== pv_addr || mem_wdata !== pv_wd))
        n_unst++;
      pv_req = mem_req; pv_ack = mem_ack; pv_we = mem_we; pv_addr = mem_addr; pv_wd = mem_wdata;
      if (toggle) begin
        req_addr = $urandom;
        req_data = $urandom;
        req_half = 1'($urandom);
        req_byte = 1'($urandom);
      end
      if ((done || misalign) && done_k == 0) begin
        done_k = k;
        break;
      end
    end

    chk("finish_seen", {31'h0, done_k != 0}, 32'h1);
    chk("n_done", n_done, ex_mis ? 32'd0 : 32'd1);
    chk("n_misalign", n_mis, ex_mis ? 32'd1 : 32'd0);
    chk("ready_busy", n_busy, 32'd0);
    chk("mem_stable", n_unst, 32'd0);
    if (ex_mis) chk("fault_no_memreq", {31'h0, mreq_seen}, 32'h0);
    if (lat == 0 || ex_mis) chk("latency", done_k, ex_mis ? 32'd1 : (rmw ? 32'd3 : 32'd2));

    @(negedge clk);
    #1;
    chk("ready_after", {31'h0, req_ready}, 32'h1);
    chk("pulse_single", {30'h0, done, misalign}, 32'h0);

    chk("op_count", ops.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ops.size(); i++) begin
      chk("op_we", {31'h0, ops[i].we}, {31'h0, exp_q[i].we});
      chk("op_addr", ops[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk("op_wdata", ops[i].data, exp_q[i].data);
    end
    if (ops.size() > 0 && ops[ops.size()-1].we) last_wr = ops[ops.size()-1].data;
  endtask

  initial begin
    logic [31:0] w;
    int          nd;
    checks = 0;
    failures = 0;
    mem_lat = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_addr = 32'h0;
    req_data = 32'h0;
    req_half = 1'b0;
    req_byte = 1'b0;

    #2;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_outs", {28'h0, done, misalign, mem_req, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_store(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0, w);
    chk("sw_word", w, 32'hDEAD_BEEF);

    preload(32'h100, 32'h1122_3344);
    do_store(32'h103, 32'h0000_00AA, 1'b0, 1'b1, 0, 0, w);
    chk("sb_lane3", w, 32'hAA22_3344);
    preload(32'h100, 32'h1122_3344);
    do_store(32'h100, 32'h0000_00AA, 1'b0, 1'b1, 0, 0, w);
    chk("sb_lane0", w, 32'h1122_33AA);
    preload(32'h100, 32'h1122_3344);
    do_store(32'h101, 32'h0000_00AA, 1'b0, 1'b1, 0, 0, w);
    chk("sb_lane1", w, 32'h1122_AA44);
    preload(32'h100, 32'h1122_3344);
    do_store(32'h102, 32'h0000_00AA, 1'b0, 1'b1, 0, 0, w);
    chk("sb_lane2", w, 32'h11AA_3344);

    preload(32'h200, 32'h1122_3344);
    do_store(32'h202, 32'h0000_BEEF, 1'b1, 1'b0, 0, 0, w);
    chk("sh_upper", w, 32'hBEEF_3344);
    preload(32'h200, 32'h1122_3344);
    do_store(32'h200, 32'h0000_BEEF, 1'b1, 1'b0, 0, 0, w);
    chk("sh_lower", w, 32'h1122_BEEF);

    do_store(32'h201, 32'h0000_BEEF, 1'b1, 1'b0, 0, 0, w);
    preload(32'h200, 32'h1122_3344);
    do_store(32'h201, 32'h0000_BEEF, 1'b1, 1'b1, 0, 0, w);
    chk("byte_prio", w, 32'h1122_EF44);

    preload(32'h500, 32'h1122_3344);
    do_store(32'h502, 32'h0000_CAFE, 1'b1, 1'b0, 3, 1, w);
    chk("sh_slow", w, 32'hCAFE_3344);
    do_store(32'h504, 32'h0BAD_F00D, 1'b0, 1'b0, 3, 1, w);
    chk("sw_slow", w, 32'h0BAD_F00D);

    // Reset while the word write is waiting for its ack.
    mem_lat = 3;
    ops.delete();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h300; req_data = 32'h1234_5678;
    req_half = 1'b0; req_byte = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_in_wr", {30'h0, mem_req, mem_we}, 32'h3);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_memreq", {31'h0, mem_req}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_addr", mem_addr, 32'h0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_mid_no_done", nd, 32'd0);
    chk("rst_mid_no_write", ops.size(), 32'd0);
    do_store(32'h300, 32'hA5A5_0F0F, 1'b0, 1'b0, 0, 0, w);
    chk("post_rst_sw", w, 32'hA5A5_0F0F);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic [31:0] rd;
      int          sz;
      ra = 32'h400 + $urandom_range(0, 63);
      rd = $urandom;
      sz = $urandom_range(0, 3);
      do_store(ra, rd, sz[0], sz[1], -1, n[0], w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
